// File: rtl/alarm_bank_if.sv
// rtl/alarm_bank_if.sv - Signal bundle between alarm_bank, the key/time logic and the sound driver.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic [3:0]            new_alarm_ms_hr;
  logic [3:0]            new_alarm_ls_hr;
  logic [3:0]            new_alarm_ms_min;
  logic [3:0]            new_alarm_ls_min;
  logic                  load_new_alarm;
  logic [IDX_W-1:0]      load_index;
  logic [NUM_ALARMS-1:0] alarm_enable;
  logic [3:0]            current_time_ms_hr;
  logic [3:0]            current_time_ls_hr;
  logic [3:0]            current_time_ms_min;
  logic [3:0]            current_time_ls_min;
  logic                  one_minute;
  logic                  stop_alarm;
  logic                  snooze;
  logic [IDX_W-1:0]      read_index;
  logic [3:0]            alarm_time_ms_hr;
  logic [3:0]            alarm_time_ls_hr;
  logic [3:0]            alarm_time_ms_min;
  logic [3:0]            alarm_time_ls_min;
  logic                  load_error;
  logic                  sound_alarm;
  logic [IDX_W-1:0]      alarm_source;

  modport master (
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output load_new_alarm, load_index, alarm_enable,
    output current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    output one_minute, stop_alarm, snooze, read_index,
    input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    input  load_error, sound_alarm, alarm_source
  );

  modport slave (
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  load_new_alarm, load_index, alarm_enable,
    input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    input  one_minute, stop_alarm, snooze, read_index,
    output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    output load_error, sound_alarm, alarm_source
  );
endinterface

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - Multi-slot BCD alarm store with ring/snooze sequencer.
// Define ALARM_SNOOZE_EN to build the SNOOZED state, snooze target and BCD adder.
module alarm_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int IDX_W        = 2,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MINUTES = 2
) (
  input logic         clock,
  input logic         reset,
  alarm_bank_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  logic [15:0]           slot_q [NUM_ALARMS];
  logic [15:0]           new_time;
  logic [15:0]           cur_time;
  logic [15:0]           rd_time;
  logic                  load_ok;
  logic                  load_err_q;
  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      src_q, src_d;
  logic [3:0]            ring_cnt_q, ring_cnt_d;
  logic                  sound_q;
  logic                  match_found;
  logic [IDX_W-1:0]      match_idx;
  logic [NUM_ALARMS-1:0] en_shifted;
  logic                  src_enabled;
  logic                  ring_done;

  assign new_time = {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                     bus.new_alarm_ms_min, bus.new_alarm_ls_min};
  assign cur_time = {bus.current_time_ms_hr, bus.current_time_ls_hr,
                     bus.current_time_ms_min, bus.current_time_ls_min};

  assign load_ok = (32'(bus.load_index) < NUM_ALARMS)
                && (bus.new_alarm_ms_hr <= 4'd2)
                && (bus.new_alarm_ls_hr <= ((bus.new_alarm_ms_hr == 4'd2) ? 4'd3 : 4'd9))
                && (bus.new_alarm_ms_min <= 4'd5)
                && (bus.new_alarm_ls_min <= 4'd9);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= bus.load_new_alarm && !load_ok;
      if (bus.load_new_alarm && load_ok) begin
        for (int i = 0; i < NUM_ALARMS; i++)
          if (32'(bus.load_index) == i) slot_q[i] <= new_time;
      end
    end
  end

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (bus.alarm_enable[i] && (slot_q[i] == cur_time)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rd_time = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (32'(bus.read_index) == i) rd_time = slot_q[i];
  end

  assign en_shifted  = bus.alarm_enable >> src_q;
  assign src_enabled = en_shifted[0];
  assign ring_done   = ({1'b0, ring_cnt_q} + 5'd1) >= 5'(RING_MINUTES);

`ifdef ALARM_SNOOZE_EN
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] snooze_time;
  logic [6:0]  min_sum;
  logic [5:0]  min_wrap;
  logic [4:0]  hr_cur;
  logic [4:0]  hr_wrap;
  logic        min_carry;

  // Add in binary, wrap minutes then hours, convert back to BCD digits.
  always_comb begin
    min_sum   = 7'(bus.current_time_ms_min) * 7'd10 + 7'(bus.current_time_ls_min)
              + 7'(SNOOZE_MIN);
    min_carry = (min_sum >= 7'd60);
    min_wrap  = min_carry ? 6'(min_sum - 7'd60) : 6'(min_sum);
    hr_cur    = 5'(bus.current_time_ms_hr) * 5'd10 + 5'(bus.current_time_ls_hr);
    hr_wrap   = hr_cur + {4'd0, min_carry};
    if (hr_wrap >= 5'd24) hr_wrap = 5'd0;
    snooze_time = {4'(hr_wrap / 5'd10), 4'(hr_wrap % 5'd10),
                   4'(min_wrap / 6'd10), 4'(min_wrap % 6'd10)};
  end
`endif

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    tgt_d      = tgt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.one_minute && match_found) begin
          state_d    = ST_RINGING;
          src_d      = match_idx;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (bus.stop_alarm || !src_enabled) begin
          state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (bus.snooze) begin
          state_d = ST_SNOOZED;
          tgt_d   = snooze_time;
`endif
        end else if (bus.one_minute) begin
          if (ring_done) state_d = ST_IDLE;
          else           ring_cnt_d = ring_cnt_q + 4'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZED: begin
        if (bus.stop_alarm || !src_enabled) begin
          state_d = ST_IDLE;
        end else if (bus.one_minute) begin
          if (match_found) begin
            state_d    = ST_RINGING;
            src_d      = match_idx;
            ring_cnt_d = '0;
            tgt_d      = '0;
          end else if (cur_time == tgt_q) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      ring_cnt_q <= '0;
      sound_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      ring_cnt_q <= ring_cnt_d;
      sound_q    <= (state_d == ST_RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tgt_q <= '0;
    else       tgt_q <= tgt_d;
  end
`endif

  assign bus.alarm_time_ms_hr  = rd_time[15:12];
  assign bus.alarm_time_ls_hr  = rd_time[11:8];
  assign bus.alarm_time_ms_min = rd_time[7:4];
  assign bus.alarm_time_ls_min = rd_time[3:0];
  assign bus.load_error        = load_err_q;
  assign bus.sound_alarm       = sound_q;
  assign bus.alarm_source      = src_q;
endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - Directed and randomized bench for alarm_bank with a minutes-of-day reference model.
module tb_alarm_bank;
  localparam int NA = 4;
  localparam int IW = 3;
  localparam int SN = 5;
  localparam int RM = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alarm_bank_if #(.NUM_ALARMS(NA), .IDX_W(IW)) bus ();

  alarm_bank #(.NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_MIN(SN), .RING_MINUTES(RM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cur_t    = 0;

  int m_slot [NA];
  int m_state, m_src, m_cnt, m_tgt;
  bit m_err;

  function automatic logic [15:0] to_bcd(int t);
    int h = t / 60;
    int m = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] read_back();
    return {bus.alarm_time_ms_hr, bus.alarm_time_ls_hr, bus.alarm_time_ms_min, bus.alarm_time_ls_min};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_slot[i] = 0;
    m_state = M_IDLE; m_src = 0; m_cnt = 0; m_tgt = 0; m_err = 1'b0;
  endtask

  // Reference: times as minutes of day, rules applied in order of precedence.
  task automatic model_step();
    int cur, h, m, win;
    bit ok, en_src;
    cur = (int'(bus.current_time_ms_hr) * 10 + int'(bus.current_time_ls_hr)) * 60
        + int'(bus.current_time_ms_min) * 10 + int'(bus.current_time_ls_min);
    win = -1;
    for (int i = NA - 1; i >= 0; i--)
      if (bus.alarm_enable[i] && m_slot[i] == cur) win = i;
    h  = int'(bus.new_alarm_ms_hr) * 10 + int'(bus.new_alarm_ls_hr);
    m  = int'(bus.new_alarm_ms_min) * 10 + int'(bus.new_alarm_ls_min);
    ok = (int'(bus.load_index) < NA) && (bus.new_alarm_ls_hr <= 9) && (bus.new_alarm_ls_min <= 9)
      && (h < 24) && (m < 60);
    en_src = bus.alarm_enable[m_src];
    m_err = bus.load_new_alarm && !ok;
    case (m_state)
      M_IDLE: if (bus.one_minute && win >= 0) begin m_state = M_RING; m_src = win; m_cnt = 0; end
      M_RING: begin
        if (bus.stop_alarm || !en_src) m_state = M_IDLE;
        else if (SNZ && bus.snooze) begin m_state = M_SNZ; m_tgt = (cur + SN) % 1440; end
        else if (bus.one_minute) begin
          m_cnt++;
          if (m_cnt >= RM) m_state = M_IDLE;
        end
      end
      default: begin
        if (bus.stop_alarm || !en_src) m_state = M_IDLE;
        else if (bus.one_minute) begin
          if (win >= 0) begin m_state = M_RING; m_src = win; m_cnt = 0; end
          else if (cur == m_tgt) begin m_state = M_RING; m_cnt = 0; end
        end
      end
    endcase
    if (bus.load_new_alarm && ok) m_slot[int'(bus.load_index)] = h * 60 + m;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_time(int t);
    cur_t = t;
    bus.current_time_ms_hr  = 4'((t / 60) / 10);
    bus.current_time_ls_hr  = 4'((t / 60) % 10);
    bus.current_time_ms_min = 4'((t % 60) / 10);
    bus.current_time_ls_min = 4'((t % 60) % 10);
  endtask

  task automatic tick_minute();
    set_time((cur_t + 1) % 1440);
    bus.one_minute = 1'b1;
    tick();
    bus.one_minute = 1'b0;
  endtask

  task automatic do_load(int idx, int a, int b, int c, int d);
    bus.load_index = IW'(idx);
    bus.new_alarm_ms_hr = 4'(a); bus.new_alarm_ls_hr = 4'(b);
    bus.new_alarm_ms_min = 4'(c); bus.new_alarm_ls_min = 4'(d);
    bus.load_new_alarm = 1'b1;
    tick();
    bus.load_new_alarm = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop_alarm = 1'b1;
    tick();
    bus.stop_alarm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    model_reset();
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL reset_sound: got %0b want 0", bus.sound_alarm); end
    n_checks++; if (bus.alarm_source !== '0) begin n_errors++; $display("FAIL reset_source: got %0d want 0", bus.alarm_source); end
    n_checks++; if (bus.load_error !== 1'b0) begin n_errors++; $display("FAIL reset_load_error: got %0b want 0", bus.load_error); end
    for (int r = 0; r < 8; r++) begin
      bus.read_index = IW'(r);
      #1;
      n_checks++; if (read_back() !== 16'h0000) begin n_errors++; $display("FAIL reset_readback[%0d]: got %h want 0000", r, read_back()); end
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_ring();
    bus.alarm_enable = '0;
    set_time(7 * 60 + 29);
    do_load(2, 0, 7, 3, 0);
    bus.read_index = 3'd2;
    #1;
    n_checks++; if (read_back() !== 16'h0730) begin n_errors++; $display("FAIL basic_readback: got %h want 0730", read_back()); end
    bus.alarm_enable = 4'b0100;
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL basic_sound: got %0b want 1", bus.sound_alarm); end
    n_checks++; if (bus.alarm_source !== 3'd2) begin n_errors++; $display("FAIL basic_source: got %0d want 2", bus.alarm_source); end
    press_stop();
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL basic_stop: got %0b want 0", bus.sound_alarm); end
  endtask

  task automatic test_load_errors();
    int tbl [3][5] = '{'{1, 2, 4, 0, 0}, '{1, 1, 2, 6, 0}, '{5, 0, 1, 0, 0}};
    for (int k = 0; k < 3; k++) begin
      do_load(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4]);
      n_checks++; if (bus.load_error !== 1'b1) begin n_errors++; $display("FAIL load_err_pulse[%0d]: got %0b want 1", k, bus.load_error); end
      tick();
      n_checks++; if (bus.load_error !== 1'b0) begin n_errors++; $display("FAIL load_err_clear[%0d]: got %0b want 0", k, bus.load_error); end
    end
    for (int r = 0; r < NA; r++) begin
      bus.read_index = IW'(r);
      #1;
      n_checks++; if (read_back() !== to_bcd(m_slot[r])) begin n_errors++; $display("FAIL load_err_slot[%0d]: got %h want %h", r, read_back(), to_bcd(m_slot[r])); end
    end
    bus.read_index = 3'd2;
    #1;
    n_checks++; if (read_back() !== 16'h0730) begin n_errors++; $display("FAIL load_err_slot2: got %h want 0730", read_back()); end
  endtask

  task automatic test_priority();
    bus.alarm_enable = '0;
    do_load(1, 0, 6, 0, 0);
    do_load(3, 0, 6, 0, 0);
    bus.alarm_enable = 4'b1010;
    set_time(5 * 60 + 59);
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL prio_sound: got %0b want 1", bus.sound_alarm); end
    n_checks++; if (bus.alarm_source !== 3'd1) begin n_errors++; $display("FAIL prio_source: got %0d want 1", bus.alarm_source); end
    press_stop();
  endtask

  task automatic test_snooze();
    logic want;
    bus.alarm_enable = '0;
    do_load(3, 2, 3, 5, 8);
    bus.alarm_enable = 4'b1000;
    set_time(23 * 60 + 57);
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL snooze_ring: got %0b want 1", bus.sound_alarm); end
    bus.snooze = 1'b1;
    tick();
    bus.snooze = 1'b0;
    want = !SNZ;
    n_checks++; if (bus.sound_alarm !== want) begin n_errors++; $display("FAIL snooze_press: got %0b want %0b", bus.sound_alarm, want); end
    for (int k = 1; k <= 5; k++) begin
      tick_minute();
      want = (m_state == M_RING);
      n_checks++; if (bus.sound_alarm !== want) begin n_errors++; $display("FAIL snooze_tick[%0d]: got %0b want %0b", k, bus.sound_alarm, want); end
    end
    if (SNZ) begin
      n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL snooze_expiry: got %0b want 1", bus.sound_alarm); end
      n_checks++; if (bus.alarm_source !== 3'd3) begin n_errors++; $display("FAIL snooze_source: got %0d want 3", bus.alarm_source); end
    end
    press_stop();
  endtask

  task automatic test_timeout();
    bus.alarm_enable = '0;
    do_load(0, 1, 0, 0, 0);
    bus.alarm_enable = 4'b0001;
    set_time(9 * 60 + 59);
    tick_minute();
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL timeout_first: got %0b want 1", bus.sound_alarm); end
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL timeout_expire: got %0b want 0", bus.sound_alarm); end
    set_time(9 * 60 + 59);
    tick_minute();
    bus.stop_alarm = 1'b1;
    bus.snooze = 1'b1;
    tick();
    bus.stop_alarm = 1'b0;
    bus.snooze = 1'b0;
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL stop_and_snooze: got %0b want 0", bus.sound_alarm); end
    for (int k = 1; k <= 6; k++) begin
      tick_minute();
      n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL stop_wins_tick[%0d]: got %0b want 0", k, bus.sound_alarm); end
    end
  endtask

  task automatic test_disable();
    bus.alarm_enable = '0;
    do_load(2, 0, 8, 0, 0);
    bus.alarm_enable = 4'b0100;
    set_time(7 * 60 + 59);
    tick_minute();
    n_checks++; if (bus.sound_alarm !== 1'b1) begin n_errors++; $display("FAIL disable_ring: got %0b want 1", bus.sound_alarm); end
    bus.alarm_enable = 4'b0000;
    tick();
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL disable_drop: got %0b want 0", bus.sound_alarm); end
  endtask

  task automatic test_reset_snoozed();
    bus.alarm_enable = '0;
    do_load(3, 1, 4, 1, 5);
    bus.alarm_enable = 4'b1000;
    set_time(14 * 60 + 14);
    tick_minute();
    bus.snooze = 1'b1;
    tick();
    bus.snooze = 1'b0;
    n_checks++; if (bus.alarm_source !== 3'd3) begin n_errors++; $display("FAIL pre_reset_source: got %0d want 3", bus.alarm_source); end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL midreset_sound: got %0b want 0", bus.sound_alarm); end
    n_checks++; if (bus.alarm_source !== '0) begin n_errors++; $display("FAIL midreset_source: got %0d want 0", bus.alarm_source); end
    for (int r = 0; r < NA; r++) begin
      bus.read_index = IW'(r);
      #1;
      n_checks++; if (read_back() !== 16'h0000) begin n_errors++; $display("FAIL midreset_slot[%0d]: got %h want 0000", r, read_back()); end
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick_minute();
      n_checks++; if (bus.sound_alarm !== 1'b0) begin n_errors++; $display("FAIL snooze_lost[%0d]: got %0b want 0", k, bus.sound_alarm); end
    end
  endtask

  task automatic test_random();
    logic        want_sound;
    logic [15:0] want_rb;
    int          t;
    set_time(600);
    bus.alarm_enable = 4'hF;
    for (int n = 0; n < 400; n++) begin
      bus.stop_alarm = ($urandom_range(0, 24) == 0);
      bus.snooze     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) bus.alarm_enable = 4'($urandom);
      bus.load_new_alarm = ($urandom_range(0, 7) == 0);
      bus.load_index = IW'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        bus.new_alarm_ms_hr  = 4'($urandom_range(0, 3));
        bus.new_alarm_ls_hr  = 4'($urandom_range(0, 11));
        bus.new_alarm_ms_min = 4'($urandom_range(0, 7));
        bus.new_alarm_ls_min = 4'($urandom_range(0, 11));
      end else begin
        t = (cur_t + $urandom_range(1, 8)) % 1440;
        {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = to_bcd(t);
      end
      bus.read_index = IW'($urandom_range(0, 7));
      bus.one_minute = ($urandom_range(0, 2) == 0);
      if (bus.one_minute) set_time((cur_t + 1) % 1440);
      tick();
      want_sound = (m_state == M_RING);
      want_rb = (int'(bus.read_index) < NA) ? to_bcd(m_slot[int'(bus.read_index)]) : 16'h0000;
      n_checks++; if (bus.sound_alarm !== want_sound) begin n_errors++; $display("FAIL rand_sound[%0d]: got %0b want %0b", n, bus.sound_alarm, want_sound); end
      n_checks++; if (bus.alarm_source !== IW'(m_src)) begin n_errors++; $display("FAIL rand_source[%0d]: got %0d want %0d", n, bus.alarm_source, m_src); end
      n_checks++; if (bus.load_error !== m_err) begin n_errors++; $display("FAIL rand_load_error[%0d]: got %0b want %0b", n, bus.load_error, m_err); end
      n_checks++; if (read_back() !== want_rb) begin n_errors++; $display("FAIL rand_readback[%0d]: got %h want %h", n, read_back(), want_rb); end
    end
    bus.stop_alarm = 1'b0;
    bus.snooze = 1'b0;
    bus.load_new_alarm = 1'b0;
    bus.one_minute = 1'b0;
  endtask

  initial begin
    bus.new_alarm_ms_hr = '0; bus.new_alarm_ls_hr = '0;
    bus.new_alarm_ms_min = '0; bus.new_alarm_ls_min = '0;
    bus.load_new_alarm = 1'b0; bus.load_index = '0; bus.alarm_enable = '0;
    bus.one_minute = 1'b0; bus.stop_alarm = 1'b0; bus.snooze = 1'b0; bus.read_index = '0;
    set_time(0);
    model_reset();
    #12;
    test_reset();
    test_basic_ring();
    test_load_errors();
    test_priority();
    test_snooze();
    test_timeout();
    test_disable();
    test_reset_snoozed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-slot alarm store and alarm sequencer for the digital watch, replacing the single loadable alarm register. Holds `NUM_ALARMS` BCD alarm times (HH:MM), validates each load, and compares enabled slots against the running time on every minute tick. It drives a registered `sound_alarm` through an idle/ringing/snoozed state machine with stop, snooze and auto-timeout. It sits between the key/alarm-entry logic, the time counter (source of `current_*` and `one_minute`) and the sound/display driver.

## Interface
Parameters:
- `NUM_ALARMS`, 4: number of alarm slots, 1..16.
- `IDX_W`, 2: index width; must satisfy 2**IDX_W >= NUM_ALARMS.
- `SNOOZE_MIN`, 5: snooze length in minutes, 1..59.
- `RING_MINUTES`, 2: minute ticks of ringing before auto-stop, 1..15.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `new_alarm_ms_hr`, `new_alarm_ls_hr`, `new_alarm_ms_min`, `new_alarm_ls_min` in 4 each: BCD alarm time to load.
- `load_new_alarm` in 1: load strobe, sampled each cycle.
- `load_index` in IDX_W: slot written on load.
- `alarm_enable` in NUM_ALARMS: per-slot arm level; bit i arms slot i.
- `current_time_ms_hr`, `current_time_ls_hr`, `current_time_ms_min`, `current_time_ls_min` in 4 each: BCD time of day.
- `one_minute` in 1: one-cycle strobe asserted when the time counter changes minute; current time is already updated in that cycle.
- `stop_alarm` in 1: stop request.
- `snooze` in 1: snooze request.
- `read_index` in IDX_W: slot selected for read-back.
- `alarm_time_ms_hr`, `alarm_time_ls_hr`, `alarm_time_ms_min`, `alarm_time_ls_min` out 4 each: stored time of slot `read_index`. Combinational mux of registers; 0 if `read_index` >= NUM_ALARMS.
- `load_error` out 1: registered one-cycle pulse for a rejected load.
- `sound_alarm` out 1: registered; high only in RINGING.
- `alarm_source` out IDX_W: registered index of the slot that caused the current ring or snooze.

## Operation
- Load is valid when `load_index` < NUM_ALARMS and the time is legal BCD: ms_hr <= 2, ls_hr <= 9 (<= 3 when ms_hr = 2), ms_min <= 5, ls_min <= 9.
- Valid load writes the slot. Invalid load leaves all slots unchanged and pulses `load_error`.
- Loads are accepted in every state and never change the state machine.
- Match: on `one_minute`, slot i matches if `alarm_enable[i]` is set and all four digits equal current time. The lowest matching index wins.
- States:
  - IDLE: a match goes to RINGING; `alarm_source` takes the winning index; the ring counter clears.
  - RINGING: `stop_alarm` goes to IDLE. `snooze` goes to SNOOZED and latches snooze target = sampled current time + SNOOZE_MIN, mod 24:00, in BCD (e.g. 23:58 + 5 = 00:03). Each `one_minute` increments the ring counter; reaching RING_MINUTES goes to IDLE. A new match while ringing is ignored and the source is kept.
  - SNOOZED: `stop_alarm` goes to IDLE. On `one_minute`, current time == target goes to RINGING with the ring counter cleared. A new slot match also goes to RINGING; the source updates and the snooze target is discarded.
- Simultaneous `stop_alarm` and `snooze`: stop wins.
- Stop or snooze arriving in the same cycle as `one_minute`: the request has priority over the tick and the match evaluation.
- `alarm_enable[alarm_source]` deasserting in RINGING or SNOOZED goes to IDLE on the next edge.

## Timing
- Reset (async): all slots 00:00, state IDLE, `sound_alarm` 0, `alarm_source` 0, `load_error` 0, ring counter 0, snooze target 00:00.
- Load: slot and read-back update on the edge that samples `load_new_alarm`. `load_error` is high the cycle after the rejected strobe, for one cycle.
- Alarm: `sound_alarm` rises on the edge that samples the matching `one_minute`, i.e. one cycle latency.
- Stop or snooze: `sound_alarm` falls on the edge sampling the request.
- Snooze-expiry ring also has one cycle latency from `one_minute`.
- Reset mid-ring or mid-snooze: immediate return to reset values; pending snooze is lost.

## Configuration
- `ALARM_SNOOZE_EN` defined: SNOOZED state, snooze target register and BCD adder are present, as described above.
- Not defined: `snooze` is ignored, SNOOZED is unreachable and not implemented, and RINGING exits only by stop, timeout or disable.

## Test plan
- Load slot 2 = 07:30, arm bit 2, drive 07:30 with `one_minute` -> `sound_alarm` = 1 next cycle, `alarm_source` = 2; `stop_alarm` -> 0.
- Load 24:00, then 12:60, then index 5 with NUM_ALARMS = 4 -> `load_error` pulses three times; read-back of all slots is unchanged.
- Slots 1 and 3 both 06:00, both armed, tick at 06:00 -> `alarm_source` = 1.
- Ring at 23:58, `snooze` -> `sound_alarm` = 0; ticks to 00:03 -> rings again, source kept. Without `ALARM_SNOOZE_EN`, `snooze` has no effect.
- Ring, no acknowledge, two further ticks (RING_MINUTES = 2) -> IDLE. Assert `stop_alarm` + `snooze` together while ringing -> IDLE, not SNOOZED.
- Assert `reset` while SNOOZED -> outputs and slots at reset values. Clear the arm bit of the source while ringing -> `sound_alarm` = 0 next cycle.
